// File: rtl/load_store_unit_if.sv
// Data-memory access interface: CPU request/response handshake plus the
// word-wide byte-enabled memory bus driven by the load/store unit.
interface load_store_unit_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 17
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            modeBU;
    logic [WIDTH-1:0]      addr;
    logic [WIDTH-1:0]      wdata;
    logic                  resp_valid;
    logic [WIDTH-1:0]      rdata;
    logic                  err;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [WIDTH-1:0]      mem_wdata;
    logic                  mem_ack;
    logic [WIDTH-1:0]      mem_rdata;

    modport master (
        input  req_valid, req_we, modeBU, addr, wdata, mem_ack, mem_rdata,
        output req_ready, resp_valid, rdata, err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        output req_valid, req_we, modeBU, addr, wdata, mem_ack, mem_rdata,
        input  req_ready, resp_valid, rdata, err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: validates one CPU access, runs a single request/ack bus
// cycle with lane-aligned data, and returns an extended load result.
module load_store_unit #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.master bus
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    localparam logic [2:0] MODE_WORD  = 3'b001;
    localparam logic [2:0] MODE_HALF  = 3'b010;
    localparam logic [2:0] MODE_BYTE  = 3'b011;
    localparam logic [2:0] MODE_HALFU = 3'b100;
    localparam logic [2:0] MODE_BYTEU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t                state_r, state_s;
    logic [CW-1:0]         cnt_r, cnt_s;
    logic [2:0]            mode_r, mode_s;
    logic [1:0]            off_r, off_s;
    logic                  we_r, we_s;
    logic                  req_ready_r, req_ready_s;
    logic                  resp_valid_r, resp_valid_s;
    logic                  err_r, err_s;
    logic [WIDTH-1:0]      rdata_r, rdata_s;
    logic                  mem_req_r, mem_req_s;
    logic                  mem_we_r, mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_s;
    logic [3:0]            mem_be_r, mem_be_s;
    logic [WIDTH-1:0]      mem_wdata_r, mem_wdata_s;
    logic                  unused_addr_s;

    // Address bits above the memory window are intentionally dropped.
    assign unused_addr_s = ^{bus.addr[WIDTH-1:ADDR_WIDTH]};

    function automatic logic access_error(input logic [2:0] mode, input logic [1:0] off);
        logic e;
        case (mode)
            MODE_WORD:             e = (off != 2'b00);
            MODE_HALF, MODE_HALFU: e = off[0];
            MODE_BYTE, MODE_BYTEU: e = 1'b0;
            default:               e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] mode, input logic [1:0] off);
        logic [3:0] be;
        case (mode)
            MODE_WORD:             be = 4'b1111;
            MODE_HALF, MODE_HALFU: be = off[1] ? 4'b1100 : 4'b0011;
            MODE_BYTE, MODE_BYTEU: be = 4'b0001 << off;
            default:               be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [WIDTH-1:0] store_lanes(input logic [2:0] mode,
                                                     input logic [WIDTH-1:0] wd);
        logic [WIDTH-1:0] r;
        case (mode)
            MODE_WORD:             r = wd;
            MODE_HALF, MODE_HALFU: r = WIDTH'({2{wd[15:0]}});
            MODE_BYTE, MODE_BYTEU: r = WIDTH'({4{wd[7:0]}});
            default:               r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] load_extract(input logic [2:0] mode,
                                                      input logic [1:0] off,
                                                      input logic [WIDTH-1:0] word);
        logic [7:0]       b;
        logic [15:0]      h;
        logic [WIDTH-1:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (mode)
            MODE_WORD:  r = word;
            MODE_HALF:  r = {{(WIDTH-16){h[15]}}, h};
            MODE_HALFU: r = {{(WIDTH-16){1'b0}}, h};
            MODE_BYTE:  r = {{(WIDTH-8){b[7]}}, b};
            MODE_BYTEU: r = {{(WIDTH-8){1'b0}}, b};
            default:    r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    // Next-state and next-output logic for the IDLE -> BUS -> DONE sequence.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        mode_s       = mode_r;
        off_s        = off_r;
        we_s         = we_r;
        resp_valid_s = 1'b0;
        err_s        = err_r;
        rdata_s      = rdata_r;
        mem_req_s    = 1'b0;
        mem_we_s     = mem_we_r;
        mem_addr_s   = mem_addr_r;
        mem_be_s     = mem_be_r;
        mem_wdata_s  = mem_wdata_r;

        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    mode_s = bus.modeBU;
                    off_s  = bus.addr[1:0];
                    we_s   = bus.req_we;
                    if (access_error(bus.modeBU, bus.addr[1:0])) begin
                        state_s      = DONE;
                        resp_valid_s = 1'b1;
                        err_s        = 1'b1;
                        rdata_s      = {WIDTH{1'b0}};
                    end else begin
                        state_s     = BUS;
                        cnt_s       = {CW{1'b0}};
                        mem_req_s   = 1'b1;
                        mem_we_s    = bus.req_we;
                        mem_addr_s  = {bus.addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_be_s    = lane_be(bus.modeBU, bus.addr[1:0]);
                        mem_wdata_s = store_lanes(bus.modeBU, bus.wdata);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            BUS: begin
                cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                if (bus.mem_ack) begin
                    state_s      = DONE;
                    resp_valid_s = 1'b1;
                    err_s        = 1'b0;
                    rdata_s      = we_r ? {WIDTH{1'b0}} : load_extract(mode_r, off_r, bus.mem_rdata);
                    mem_we_s     = 1'b0;
                end else if (cnt_s == CW'(TIMEOUT)) begin
                    // Give up: the memory side never answered within the window.
                    state_s      = DONE;
                    resp_valid_s = 1'b1;
                    err_s        = 1'b1;
                    rdata_s      = {WIDTH{1'b0}};
                    mem_we_s     = 1'b0;
                end else begin
                    mem_req_s = 1'b1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        req_ready_s = (state_s == IDLE);
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= {CW{1'b0}};
            mode_r       <= 3'b000;
            off_r        <= 2'b00;
            we_r         <= 1'b0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            err_r        <= 1'b0;
            rdata_r      <= {WIDTH{1'b0}};
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_WIDTH{1'b0}};
            mem_be_r     <= 4'b0000;
            mem_wdata_r  <= {WIDTH{1'b0}};
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            mode_r       <= mode_s;
            off_r        <= off_s;
            we_r         <= we_s;
            req_ready_r  <= req_ready_s;
            resp_valid_r <= resp_valid_s;
            err_r        <= err_s;
            rdata_r      <= rdata_s;
            mem_req_r    <= mem_req_s;
            mem_we_r     <= mem_we_s;
            mem_addr_r   <= mem_addr_s;
            mem_be_r     <= mem_be_s;
            mem_wdata_r  <= mem_wdata_s;
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.err        = err_r;
    assign bus.rdata      = rdata_r;
    assign bus.mem_req    = mem_req_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_be     = mem_be_r;
    assign bus.mem_wdata  = mem_wdata_r;
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: the CPU datapath hands it one load/store per transaction.
- Checks alignment and mode, then drives a word-wide, byte-enabled request/acknowledge bus to data memory.
- Extracts, sign-extends or zero-extends load data and returns a single-cycle response.
- Sits between the execute stage and data memory; its req_ready low is the datapath stall.

Parameters:
- WIDTH, 32, data and CPU address width.
- ADDR_WIDTH, 17, memory byte-address width; mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}, upper address bits ignored.
- TIMEOUT, 16, max BUS cycles waiting for mem_ack before error; counter width $clog2(TIMEOUT)+1.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU access request.
- req_ready  out  1  high only in IDLE; a transfer occurs when req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- modeBU  in  3  001 word, 010 half, 011 byte, 100 half unsigned, 101 byte unsigned; others illegal.
- addr  in  WIDTH  byte address.
- wdata  in  WIDTH  store data, in the low bits.
- resp_valid  out  1  one-cycle completion pulse.
- rdata  out  WIDTH  load result; 0 for stores and errors.
- err  out  1  valid with resp_valid: misaligned, illegal mode or timeout.
- mem_req  out  1  bus request, held until ack.
- mem_we  out  1  bus write.
- mem_addr  out  ADDR_WIDTH  word-aligned byte address.
- mem_be  out  4  byte enables; bit i = bits 8i+7:8i = byte offset i (little-endian).
- mem_wdata  out  WIDTH  lane-replicated store data.
- mem_ack  in  1  memory completes the current request this cycle.
- mem_rdata  in  WIDTH  whole aligned word, valid with mem_ack.

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid, err, mem_req, mem_we = 0; rdata, mem_addr, mem_be, mem_wdata, counter = 0.
- Reset mid-operation: aborts any state; mem_req low the cycle after reset; a late mem_ack in IDLE is ignored.
- Request inputs are captured on the accept edge; the CPU may change them afterwards.
- IDLE, on accept:
  - Illegal mode, or word with addr[1:0]!=0, or half (010/100) with addr[0]!=0: go to DONE with err=1; no bus cycle.
  - Otherwise go to BUS.
- BUS:
  - mem_req=1; mem_we, mem_addr, mem_be, mem_wdata stable for the whole state.
  - On mem_ack: capture the load result, go to DONE with err=0.
  - If the counter reaches TIMEOUT with no ack: go to DONE with err=1; mem_req drops.
  - Counter increments every BUS cycle and clears on entry to BUS.
- DONE: resp_valid=1 for exactly one cycle; return to IDLE. A new request is accepted no earlier than the following cycle.
- Latency: accept at edge N; ack in the first BUS cycle gives resp_valid in cycle N+2. Error path: resp_valid in cycle N+1.
- Store lanes (off = addr[1:0]):
  - Byte: mem_wdata={4{wdata[7:0]}}, mem_be=4'b0001<<off.
  - Half: mem_wdata={2{wdata[15:0]}}, mem_be=0011 (off 0) or 1100 (off 2).
  - Word: mem_wdata=wdata, mem_be=1111.
- Loads: mem_we=0, mem_be as for stores (informational).
  - Byte = mem_rdata[8*off+:8]; half = mem_rdata[8*off+:16].
  - Modes 010/011 sign-extend; 100/101 zero-extend.
- rdata and err hold their value until the next DONE.

Test Plan:
- Reset then store word addr=0x100, wdata=0xDEADBEEF, ack in first BUS cycle -> mem_addr=0x100, mem_be=1111, mem_wdata=0xDEADBEEF; resp_valid 2 cycles after accept; err=0.
- Store byte addr=0x103, wdata=0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5; load byte (011) same addr, mem_rdata=0xA5000000 -> rdata=0xFFFFFFA5; load byte unsigned (101) -> rdata=0x000000A5.
- Load half (010) addr=0x102, mem_rdata=0x80010000 -> rdata=0xFFFF8001; half unsigned (100) -> rdata=0x00008001.
- Load word addr=0x102, then modeBU=3'b111 -> each gives resp_valid one cycle after accept with err=1; mem_req never asserted.
- Memory never acks, TIMEOUT=16 -> mem_req high 16 cycles, then resp_valid with err=1; req_ready returns high the next cycle.
- rst asserted during BUS with ack pending -> IDLE and mem_req=0 the next cycle; ack arriving later causes no resp_valid.
